// File: rtl/ctrl_fsm.sv
// Multicycle main control FSM for the mips core: FETCH/DCD/EXE/ALUWB/MEMRD/MEMWB/MEMWR/BR/JMP.
// Optional macro CTRL_JAL_EN enables jal decode; without it opcode 000011 is illegal.
module ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic [1:0] EXTOp,
    output logic [1:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic       BSel,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       Illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DCD,
        S_EXE,
        S_ALUWB,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BR,
        S_JMP
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;
    logic [5:0] r_funct;

    logic w_is_addu;
    logic w_is_subu;
    logic w_is_rtype;
    logic w_is_ori;
    logic w_is_lui;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_beq;
    logic w_is_j;
    logic w_is_jal;
    logic w_is_alu_i;
    logic w_is_mem;
    logic w_legal;

    logic       w_bsel_ex;
    logic [1:0] w_extop_ex;
    logic [1:0] w_aluop_ex;

    // All decode below looks at the shadow copy; IM output moves once PC updates.
    assign w_is_addu  = (r_op == OP_RTYPE) && (r_funct == FN_ADDU);
    assign w_is_subu  = (r_op == OP_RTYPE) && (r_funct == FN_SUBU);
    assign w_is_rtype = w_is_addu || w_is_subu;
    assign w_is_ori   = (r_op == OP_ORI);
    assign w_is_lui   = (r_op == OP_LUI);
    assign w_is_lw    = (r_op == OP_LW);
    assign w_is_sw    = (r_op == OP_SW);
    assign w_is_beq   = (r_op == OP_BEQ);
    assign w_is_j     = (r_op == OP_J);
`ifdef CTRL_JAL_EN
    assign w_is_jal   = (r_op == OP_JAL);
`else
    assign w_is_jal   = 1'b0;
`endif
    assign w_is_alu_i = w_is_ori || w_is_lui;
    assign w_is_mem   = w_is_lw || w_is_sw;
    assign w_legal    = w_is_rtype || w_is_alu_i || w_is_mem ||
                        w_is_beq || w_is_j || w_is_jal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_funct <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) begin
                r_op    <= Op;
                r_funct <= Funct;
            end
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DCD;
            S_DCD: begin
                if (w_is_rtype || w_is_alu_i || w_is_mem) begin
                    w_next = S_EXE;
                end else if (w_is_beq) begin
                    w_next = S_BR;
                end else if (w_is_j || w_is_jal) begin
                    w_next = S_JMP;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_EXE: begin
                if (w_is_lw) begin
                    w_next = S_MEMRD;
                end else if (w_is_sw) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_ALUWB;
                end
            end
            S_MEMRD: w_next = S_MEMWB;
            default: w_next = S_FETCH;
        endcase
    end

    // ALU/EXT selects shared by EXE and the states that must hold them afterwards.
    always_comb begin
        w_bsel_ex  = 1'b0;
        w_extop_ex = 2'b00;
        w_aluop_ex = 2'b00;
        if (w_is_subu) begin
            w_aluop_ex = 2'b01;
        end else if (w_is_ori) begin
            w_bsel_ex  = 1'b1;
            w_aluop_ex = 2'b10;
        end else if (w_is_lui) begin
            w_bsel_ex  = 1'b1;
            w_extop_ex = 2'b10;
        end else if (w_is_mem) begin
            w_bsel_ex  = 1'b1;
            w_extop_ex = 2'b01;
        end
    end

    always_comb begin
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        DMWr    = 1'b0;
        EXTOp   = 2'b00;
        ALUOp   = 2'b00;
        NPCOp   = 2'b00;
        BSel    = 1'b0;
        GPRSel  = 2'b00;
        WDSel   = 2'b00;
        Illegal = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    PCWr = 1'b1;
                    IRWr = 1'b1;
                end
                S_DCD: Illegal = !w_legal;
                S_EXE, S_MEMRD: begin
                    BSel  = w_bsel_ex;
                    EXTOp = w_extop_ex;
                    ALUOp = w_aluop_ex;
                end
                S_ALUWB: begin
                    BSel   = w_bsel_ex;
                    EXTOp  = w_extop_ex;
                    ALUOp  = w_aluop_ex;
                    RFWr   = 1'b1;
                    GPRSel = w_is_rtype ? 2'b01 : 2'b00;
                end
                S_MEMWB: begin
                    RFWr  = 1'b1;
                    WDSel = 2'b01;
                end
                S_MEMWR: begin
                    BSel  = w_bsel_ex;
                    EXTOp = w_extop_ex;
                    ALUOp = w_aluop_ex;
                    DMWr  = 1'b1;
                end
                S_BR: begin
                    ALUOp = 2'b01;
                    EXTOp = 2'b01;
                    NPCOp = 2'b01;
                    PCWr  = Zero;
                end
                S_JMP: begin
                    NPCOp = 2'b10;
                    PCWr  = 1'b1;
                    if (w_is_jal) begin
                        RFWr   = 1'b1;
                        GPRSel = 2'b10;
                        WDSel  = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: per-instruction expected output sequences
// from an instruction-level model, randomized inputs in non-FETCH cycles.
module tb_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWr, IRWr, RFWr, DMWr, BSel, Illegal;
    logic [1:0] EXTOp, ALUOp, NPCOp, GPRSel, WDSel;

    ctrl_fsm dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr),
        .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .BSel(BSel),
        .GPRSel(GPRSel), .WDSel(WDSel), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    typedef logic [15:0] vec_t;
    vec_t obs;
    assign obs = {PCWr, IRWr, RFWr, DMWr, EXTOp, ALUOp, NPCOp, BSel, GPRSel, WDSel, Illegal};

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    vec_t        exp_seq [5];
    int          exp_len;

    function automatic vec_t mk(input logic pcwr, input logic irwr, input logic rfwr,
                                input logic dmwr, input logic [1:0] extop,
                                input logic [1:0] aluop, input logic [1:0] npcop,
                                input logic bsel, input logic [1:0] gprsel,
                                input logic [1:0] wdsel, input logic ill);
        return {pcwr, irwr, rfwr, dmwr, extop, aluop, npcop, bsel, gprsel, wdsel, ill};
    endfunction

    task automatic check(input string tag, input vec_t o, input vec_t e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Cycle-by-cycle outputs of one instruction, starting in FETCH.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic zbr);
        vec_t z;
        z = '0;
        exp_seq[0] = mk(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        for (int i = 1; i < 5; i++) exp_seq[i] = z;
        exp_len = 2;
        if (op == 6'b000000 && fn == 6'b100001) begin
            exp_seq[2] = z;
            exp_seq[3] = mk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0);
            exp_len = 4;
        end else if (op == 6'b000000 && fn == 6'b100011) begin
            exp_seq[2] = mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0);
            exp_seq[3] = mk(0, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 2'b01, 2'b00, 0);
            exp_len = 4;
        end else if (op == 6'b001101) begin
            exp_seq[2] = mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 1, 2'b00, 2'b00, 0);
            exp_seq[3] = mk(0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 1, 2'b00, 2'b00, 0);
            exp_len = 4;
        end else if (op == 6'b001111) begin
            exp_seq[2] = mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0);
            exp_seq[3] = mk(0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0);
            exp_len = 4;
        end else if (op == 6'b100011) begin
            exp_seq[2] = mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0);
            exp_seq[3] = exp_seq[2];
            exp_seq[4] = mk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b01, 0);
            exp_len = 5;
        end else if (op == 6'b101011) begin
            exp_seq[2] = mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0);
            exp_seq[3] = mk(0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0);
            exp_len = 4;
        end else if (op == 6'b000100) begin
            exp_seq[2] = mk(zbr, 0, 0, 0, 2'b01, 2'b01, 2'b01, 0, 2'b00, 2'b00, 0);
            exp_len = 3;
        end else if (op == 6'b000010) begin
            exp_seq[2] = mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 2'b00, 2'b00, 0);
            exp_len = 3;
`ifdef CTRL_JAL_EN
        end else if (op == 6'b000011) begin
            exp_seq[2] = mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b10, 0, 2'b10, 2'b10, 0);
            exp_len = 3;
`endif
        end else begin
            exp_seq[1] = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 1);
            exp_len = 2;
        end
    endtask

    // zmode: 0 random Zero, 1 force Zero=1, 2 force Zero=0
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input int zmode);
        logic zv [5];
        for (int i = 0; i < 5; i++)
            zv[i] = (zmode == 0) ? 1'($urandom % 2) : (zmode == 1);
        build(op, fn, zv[2]);
        for (int k = 0; k < exp_len; k++) begin
            @(negedge clk);
            rst = 1'b0;
            if (k == 0) begin
                Op    = op;
                Funct = fn;
            end else begin
                Op    = 6'($urandom);
                Funct = 6'($urandom);
            end
            Zero = zv[k];
            #1;
            check($sformatf("%s_c%0d", tag, k), obs, exp_seq[k]);
        end
    endtask

    initial begin
        logic [5:0] op_t [9];
        logic [5:0] fn_t [9];
        op_t = '{6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b100011,
                 6'b101011, 6'b000100, 6'b000010, 6'b000011};
        fn_t = '{6'b100001, 6'b100011, 6'b000000, 6'b000000, 6'b000000,
                 6'b000000, 6'b000000, 6'b000000, 6'b000000};
        rst   = 1'b1;
        Op    = '0;
        Funct = '0;
        Zero  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            Op    = 6'($urandom);
            Funct = 6'($urandom);
            Zero  = 1'($urandom % 2);
            #1;
            check($sformatf("reset_%0d", i), obs, '0);
        end

        run_instr("addu", 6'b000000, 6'b100001, 0);
        run_instr("subu", 6'b000000, 6'b100011, 0);
        run_instr("ori",  6'b001101, 6'b000000, 0);
        run_instr("lui",  6'b001111, 6'b000000, 0);
        run_instr("lw",   6'b100011, 6'b000000, 0);
        run_instr("sw",   6'b101011, 6'b000000, 0);
        run_instr("beq_z1", 6'b000100, 6'b000000, 1);
        run_instr("beq_z0", 6'b000100, 6'b000000, 2);
        run_instr("j",    6'b000010, 6'b000000, 0);
        run_instr("jal",  6'b000011, 6'b000000, 0);
        run_instr("ill_op", 6'b111111, 6'b000000, 0);
        run_instr("ill_fn", 6'b000000, 6'b000000, 0);

        // Reset asserted during MEMRD of an lw aborts it.
        build(6'b100011, 6'b000000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                Op    = 6'b100011;
                Funct = 6'b000000;
            end else begin
                Op    = 6'($urandom);
                Funct = 6'($urandom);
            end
            rst = (k == 3);
            #1;
            check($sformatf("lw_abort_c%0d", k), obs, (k == 3) ? vec_t'('0) : exp_seq[k]);
        end
        @(negedge clk);
        #1;
        check("lw_abort_hold", obs, '0);
        run_instr("after_abort", 6'b000000, 6'b100001, 0);

        for (int n = 0; n < 80; n++) begin
            int unsigned sel;
            sel = $urandom_range(0, 11);
            if (sel < 9)
                run_instr($sformatf("rnd%0d", n), op_t[sel], fn_t[sel], 0);
            else if (sel == 9)
                run_instr($sformatf("rnd%0d", n), 6'b000000, 6'($urandom), 0);
            else
                run_instr($sformatf("rnd%0d", n), 6'($urandom), 6'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
